// File: rtl/mwb_dump_reader.sv
// MEM/WB latch dump reader: snapshots the frozen pipeline latch and streams it
// as a 16-byte checksummed frame over a valid/ready byte interface.
module mwb_dump_reader #(
   parameter int          NB_REG  = 32,
   parameter int          NB_ADDR = 5,
   parameter int          NB_CTRL = 4,
   parameter logic [7:0]  HEADER  = 8'hA5
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_dunit_clk_en,
   input  logic               i_dump_start,
   input  logic [NB_REG-1:0]  i_pc_eight,
   input  logic [NB_REG-1:0]  i_read_data,
   input  logic [NB_REG-1:0]  i_alu_res,
   input  logic [NB_ADDR-1:0] i_data_addr,
   input  logic [NB_CTRL-1:0] i_control,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_start_rej
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_r;
   logic [3:0]        idx_r;
   logic [31:0]       pc_r;
   logic [31:0]       rd_r;
   logic [31:0]       alu_r;
   logic [7:0]        addr_r;
   logic [7:0]        ctrl_r;
   logic [7:0]        csum_r;
   logic [3:0]        next_idx_s;
   logic [7:0]        next_byte_s;

   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         2'd3:    b = w[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] fold_word(input logic [31:0] w);
      return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
   endfunction

   assign next_idx_s = idx_r + 4'd1;

   // Byte that follows the one currently presented, taken from the snapshot only.
   always_comb begin
      next_byte_s = 8'h00;
      case (next_idx_s)
         4'd0:                      next_byte_s = HEADER;
         4'd1, 4'd2, 4'd3, 4'd4:    next_byte_s = word_byte(pc_r,  2'(next_idx_s - 4'd1));
         4'd5, 4'd6, 4'd7, 4'd8:    next_byte_s = word_byte(rd_r,  2'(next_idx_s - 4'd5));
         4'd9, 4'd10, 4'd11, 4'd12: next_byte_s = word_byte(alu_r, 2'(next_idx_s - 4'd9));
         4'd13:                     next_byte_s = addr_r;
         4'd14:                     next_byte_s = ctrl_r;
         4'd15:                     next_byte_s = csum_r;
         default:                   next_byte_s = 8'h00;
      endcase
   end

   // Frame sequencer with snapshot capture and registered handshake outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r     <= ST_IDLE;
         idx_r       <= 4'd0;
         pc_r        <= 32'h0000_0000;
         rd_r        <= 32'h0000_0000;
         alu_r       <= 32'h0000_0000;
         addr_r      <= 8'h00;
         ctrl_r      <= 8'h00;
         csum_r      <= 8'h00;
         o_tx_data   <= 8'h00;
         o_tx_valid  <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_start_rej <= 1'b0;
      end else begin
         o_done      <= 1'b0;
         o_start_rej <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (i_dump_start && !i_dunit_clk_en) begin
                  pc_r       <= i_pc_eight;
                  rd_r       <= i_read_data;
                  alu_r      <= i_alu_res;
                  addr_r     <= 8'(i_data_addr);
                  ctrl_r     <= 8'(i_control);
                  // Checksum of the captured values equals the snapshot checksum.
                  csum_r     <= HEADER ^ fold_word(i_pc_eight) ^ fold_word(i_read_data)
                                ^ fold_word(i_alu_res) ^ 8'(i_data_addr) ^ 8'(i_control);
                  idx_r      <= 4'd0;
                  o_tx_data  <= HEADER;
                  o_tx_valid <= 1'b1;
                  o_busy     <= 1'b1;
                  state_r    <= ST_SEND;
               end else if (i_dump_start) begin
                  o_start_rej <= 1'b1;
               end else begin
                  o_tx_valid <= 1'b0;
               end
            end
            ST_SEND: begin
               if (o_tx_valid && i_tx_ready) begin
                  if (idx_r == 4'd15) begin
                     o_tx_valid <= 1'b0;
                     o_tx_data  <= 8'h00;
                     o_done     <= 1'b1;
                     state_r    <= ST_DONE;
                  end else begin
                     idx_r     <= next_idx_s;
                     o_tx_data <= next_byte_s;
                  end
               end else begin
                  o_tx_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               idx_r   <= 4'd0;
               o_busy  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               idx_r      <= 4'd0;
               o_tx_valid <= 1'b0;
               o_busy     <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
